// File: rtl/operand_fetch.sv
// Purpose : fetches N_PAIRS operand pairs from a synchronous-read memory and
//           hands each pair to the multiplier datapath over valid/ready.
// Latency : start -> first out_valid in 4 cycles; 4 cycles per pair minimum;
//           a full job takes 4*N_PAIRS + 1 cycles from start to done.
// Backpressure: out_ready low holds PRESENT with stable operands and issues
//           no memory reads; start is ignored everywhere except IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start               one-cycle job request (IDLE only)
//   mem_rd, mem_addr    read request to the operand memory
//   mem_rdata           read data, valid one cycle after mem_rd
//   op_a, op_b          registered operand pair
//   out_valid/out_ready pair handshake toward the datapath
//   pair_idx            index of the pair being fetched or presented
//   busy, done          job in progress / one-cycle completion pulse
module operand_fetch #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int N_PAIRS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-2:0] pair_idx,
  output logic              busy,
  output logic              done
);

  localparam int            K_W    = ADDR_W - 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_LATCH_B,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [K_W-1:0] k, k_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      // Read data lags the request by one cycle: A arrives while B is
      // being requested, B arrives in the cycle after.
      if (state == S_FETCH_B) op_a <= mem_rdata;
      if (state == S_LATCH_B) op_b <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_FETCH_A;
          k_nxt     = '0;
        end
      end
      S_FETCH_A: begin
        mem_rd    = 1'b1;
        mem_addr  = {k, 1'b0};
        state_nxt = S_FETCH_B;
      end
      S_FETCH_B: begin
        mem_rd    = 1'b1;
        mem_addr  = {k, 1'b1};
        state_nxt = S_LATCH_B;
      end
      S_LATCH_B: begin
        state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (k == K_LAST) begin
            state_nxt = S_DONE;
          end else begin
            k_nxt     = k + 1'b1;
            state_nxt = S_FETCH_A;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        k_nxt     = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        k_nxt     = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign pair_idx = k;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // Eight-pair instance
  logic        start8 = 1'b0, ready8 = 1'b1;
  logic        mem_rd8, out_valid8, busy8, done8;
  logic [3:0]  addr8;
  logic [2:0]  idx8;
  logic [15:0] rdata8, op_a8, op_b8;
  logic [15:0] mem8 [16];

  // Single-pair instance
  logic        start1 = 1'b0, ready1 = 1'b1;
  logic        mem_rd1, out_valid1, busy1, done1;
  logic [3:0]  addr1;
  logic [2:0]  idx1;
  logic [15:0] rdata1, op_a1, op_b1;
  logic [15:0] mem1 [16];

  operand_fetch #(.ADDR_W(4), .DATA_W(16), .N_PAIRS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mem_rd(mem_rd8), .mem_addr(addr8),
    .mem_rdata(rdata8), .op_a(op_a8), .op_b(op_b8), .out_valid(out_valid8),
    .out_ready(ready8), .pair_idx(idx8), .busy(busy8), .done(done8));

  operand_fetch #(.ADDR_W(4), .DATA_W(16), .N_PAIRS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mem_rd(mem_rd1), .mem_addr(addr1),
    .mem_rdata(rdata1), .op_a(op_a1), .op_b(op_b1), .out_valid(out_valid1),
    .out_ready(ready1), .pair_idx(idx1), .busy(busy1), .done(done1));

  // Synchronous-read memories
  always @(posedge clk) if (mem_rd8) rdata8 <= mem8[addr8];
  always @(posedge clk) if (mem_rd1) rdata1 <= mem1[addr1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  pair_t exp_q8[$];
  pair_t exp_q1[$];
  int    dones8 = 0;
  int    reads8 = 0;

  // Monitors: pop an expected pair on every accepted handshake
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid8 === 1'b1 && ready8 === 1'b1) begin
      if (exp_q8.size() == 0) begin
        check("sb8_unexpected_pair", {op_a8, op_b8}, 64'hx);
      end else begin
        pair_t e;
        e = exp_q8.pop_front();
        check("sb8_pair", {idx8, op_a8, op_b8}, {e.idx, e.a, e.b});
      end
    end
    if (rst === 1'b1 && done8 === 1'b1) dones8++;
    if (rst === 1'b1 && mem_rd8 === 1'b1) reads8++;
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid1 === 1'b1 && ready1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        check("sb1_unexpected_pair", {op_a1, op_b1}, 64'hx);
      end else begin
        pair_t e;
        e = exp_q1.pop_front();
        check("sb1_pair", {idx1, op_a1, op_b1}, {e.idx, e.a, e.b});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed pairs for mem8[i] = i*0x0101
  task automatic push_job8();
    for (int p = 0; p < 8; p++) begin
      pair_t e;
      e.idx = 3'(p);
      e.a   = 16'((2 * p) * 16'h0101);
      e.b   = 16'((2 * p + 1) * 16'h0101);
      exp_q8.push_back(e);
    end
  endtask

  int c, d0, r0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem8[i] = 16'(i * 16'h0101);
      mem1[i] = 16'hDEAD;
    end
    mem1[0] = 16'h1234;
    mem1[1] = 16'hABCD;

    // Reset with start asserted
    rst = 1'b0; start8 = 1'b1; start1 = 1'b1;
    step(); step();
    check("rst_outputs8", {busy8, out_valid8, mem_rd8, done8, addr8, idx8, op_a8, op_b8}, 64'h0);
    check("rst_outputs1", {busy1, out_valid1, mem_rd1, done1, addr1, idx1, op_a1, op_b1}, 64'h0);
    start8 = 1'b0; start1 = 1'b0; rst = 1'b1;
    step(); step(); step();
    check("idle_after_rst", {busy8, mem_rd8, busy1, mem_rd1}, 64'h0);

    // Single pair (N_PAIRS=1)
    begin
      pair_t e;
      e.idx = 3'd0; e.a = 16'h1234; e.b = 16'hABCD;
      exp_q1.push_back(e);
    end
    start1 = 1'b1; step(); start1 = 1'b0;                           // cycle 1
    check("sp_c1_rd", {mem_rd1, addr1}, {1'b1, 4'h0});
    step();                                                          // cycle 2
    check("sp_c2_rd", {mem_rd1, addr1}, {1'b1, 4'h1});
    step();                                                          // cycle 3
    check("sp_c3_idle_rd", {mem_rd1, out_valid1}, 64'h0);
    step();                                                          // cycle 4
    check("sp_c4_valid", {out_valid1, op_a1, op_b1}, {1'b1, 16'h1234, 16'hABCD});
    step();                                                          // cycle 5
    check("sp_c5_done", {done1, busy1, out_valid1}, {1'b1, 1'b1, 1'b0});
    step();                                                          // cycle 6
    check("sp_c6_idle", {done1, busy1}, 64'h0);
    check("sp_keep_ops", {op_a1, op_b1}, {16'h1234, 16'hABCD});
    check("sp_queue_empty", exp_q1.size(), 0);

    // Full job, out_ready held high
    ready8 = 1'b1; d0 = dones8; r0 = reads8;
    push_job8();
    start8 = 1'b1; step(); start8 = 1'b0;
    check("fj_first_rd", {mem_rd8, addr8}, {1'b1, 4'h0});
    c = 1;
    while (!done8 && c < 60) begin step(); c++; end
    check("fj_done_cycle", c, 33);
    step(); step();
    check("fj_done_count", dones8 - d0, 1);
    check("fj_read_count", reads8 - r0, 16);
    check("fj_queue_empty", exp_q8.size(), 0);
    check("fj_idle", busy8, 1'b0);

    // Backpressure on pair 2, ignored starts in FETCH_B and DONE
    d0 = dones8; r0 = reads8;
    push_job8();
    start8 = 1'b1; step(); start8 = 1'b0;
    for (int cy = 1; cy <= 40; cy++) begin
      start8 = (cy == 2 || cy == 38);
      ready8 = !(cy >= 12 && cy <= 16);
      if (cy == 2)  check("bp_fetch_b", {mem_rd8, addr8}, {1'b1, 4'h1});
      if (cy >= 13 && cy <= 16) begin
        check("bp_stall_valid", {out_valid8, mem_rd8, idx8}, {1'b1, 1'b0, 3'd2});
        check("bp_stall_ops", {op_a8, op_b8}, {16'h0404, 16'h0505});
      end
      if (cy == 18) check("bp_resume_pair3", {mem_rd8, addr8, idx8}, {1'b1, 4'h6, 3'd3});
      if (cy == 37) check("bp_not_done_early", done8, 1'b0);
      if (cy == 38) check("bp_done_cycle", done8, 1'b1);
      step();
    end
    start8 = 1'b0;
    check("bp_no_restart", {busy8, mem_rd8}, 64'h0);
    check("bp_done_count", dones8 - d0, 1);
    check("bp_read_count", reads8 - r0, 16);
    check("bp_queue_empty", exp_q8.size(), 0);

    // Reset during PRESENT of pair 3
    ready8 = 1'b1; d0 = dones8;
    push_job8();
    start8 = 1'b1; step(); start8 = 1'b0;
    for (int cy = 1; cy <= 16; cy++) begin
      if (cy == 16) begin
        check("rm_present3", {out_valid8, idx8}, {1'b1, 3'd3});
        ready8 = 1'b0;
        rst    = 1'b0;
      end
      step();
    end
    rst = 1'b1;
    check("rm_cleared", {out_valid8, idx8, busy8, done8, mem_rd8}, 64'h0);
    check("rm_unconsumed", exp_q8.size(), 5);
    exp_q8.delete();
    for (int cy = 0; cy < 10; cy++) step();
    check("rm_no_done", dones8 - d0, 0);
    ready8 = 1'b1;
    push_job8();
    start8 = 1'b1; step(); start8 = 1'b0;
    check("rm_refetch_addr0", {mem_rd8, addr8, idx8}, {1'b1, 4'h0, 3'd0});
    c = 1;
    while (!done8 && c < 60) begin step(); c++; end
    check("rm_rerun_done_cycle", c, 33);
    step();
    check("rm_rerun_done_count", dones8 - d0, 1);
    check("rm_rerun_queue_empty", exp_q8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Upstream feeder for the approximate-multiplier datapath.
- On a start pulse, reads N_PAIRS consecutive 16-bit operand pairs from the input operand memory through a synchronous read port.
- Presents each pair to the datapath with a valid/ready handshake, and pulses done after the last pair is accepted.
- Sits between the input memory and the datapath's operand shift-register load stage.

Parameters:
- ADDR_W, 4, memory address width in bits; the memory holds 2**ADDR_W words.
- DATA_W, 16, operand width in bits.
- N_PAIRS, 8, operand pairs per job; must satisfy 1 <= N_PAIRS <= 2**(ADDR_W-1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle job request; sampled only in IDLE.
- mem_rd  output  1  memory read enable.
- mem_addr  output  ADDR_W  memory read address.
- mem_rdata  input  DATA_W  read data; valid exactly 1 cycle after mem_rd=1.
- op_a  output  DATA_W  first operand of the current pair; register output.
- op_b  output  DATA_W  second operand of the current pair; register output.
- out_valid  output  1  op_a/op_b hold a valid pair.
- out_ready  input  1  datapath accepts the pair when out_valid & out_ready.
- pair_idx  output  ADDR_W-1  index k of the pair currently being fetched or presented.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Reset, when rst=0 at a clock edge:
  - state=IDLE; k=0.
  - op_a=0, op_b=0.
  - out_valid=0, mem_rd=0, mem_addr=0, busy=0, done=0.
  - Reset has priority over every other input.
  - Reset mid-job abandons the job: no done pulse is produced, and the partial pair is discarded.
- FSM states and transitions:
  - IDLE: start=1 -> FETCH_A with k=0; otherwise stay.
  - FETCH_A: mem_rd=1, mem_addr=2k -> FETCH_B.
  - FETCH_B: mem_rd=1, mem_addr=2k+1; op_a <= mem_rdata at the end of the cycle -> LATCH_B.
  - LATCH_B: mem_rd=0; op_b <= mem_rdata at the end of the cycle -> PRESENT.
  - PRESENT: out_valid=1; op_a/op_b held stable.
    - out_ready=0: stay; out_valid stays high and the operands do not change.
    - out_ready=1 and k<N_PAIRS-1: k<=k+1 -> FETCH_A.
    - out_ready=1 and k=N_PAIRS-1: -> DONE.
  - DONE: done=1 for this cycle only -> IDLE; k<=0.
- Output decoding: mem_rd and mem_addr are decoded from the state and are stable for the whole cycle; mem_addr=0 when mem_rd=0.
- Latency:
  - start sampled at edge 0 -> FETCH_A in cycle 1 -> out_valid=1 in cycle 4.
  - Minimum 4 cycles per pair when out_ready is held high.
  - Full job with out_ready=1 throughout: 4*N_PAIRS + 1 cycles from start to the done pulse.
- out_valid is cleared in the cycle after the handshake, i.e. there are no back-to-back valid cycles.
- Address arithmetic: mem_addr = {k, 0} for operand A and {k, 1} for operand B. No wrap is possible within a job; k returns to 0 only through DONE or reset.
- Boundary conditions:
  - start while busy is ignored and not queued.
  - start in the same cycle as the DONE state is ignored; a new job needs start in IDLE.
  - out_ready while out_valid=0 has no effect.
  - N_PAIRS=1: a single pair, then done.
- op_a/op_b keep the last pair after DONE until the next job overwrites them.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=0 for 2 cycles with start=1.
  - Required: all outputs 0 and no mem_rd; after rst=1, outputs stay idle until a new start.
- Single pair:
  - Stimulus: memory words 0x1234 at addr 0 and 0xABCD at addr 1, N_PAIRS=1, out_ready=1, start at cycle 0.
  - Required: mem_rd at cycles 1-2 with addr 0 then 1; out_valid=1 at cycle 4 with op_a=0x1234, op_b=0xABCD; done at cycle 5; busy low at cycle 6.
- Full job:
  - Stimulus: mem[i]=i*0x0101, N_PAIRS=8, out_ready=1.
  - Required: 8 handshakes; pair k gives op_a=(2k)*0x0101 and op_b=(2k+1)*0x0101; pair_idx runs 0..7; done at cycle 33.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during pair 2.
  - Required: out_valid held high with op_a/op_b unchanged; mem_rd=0 throughout the stall; the sequence resumes with pair 3 after out_ready=1.
- Ignored start:
  - Stimulus: pulse start during FETCH_B of pair 0 and again during DONE.
  - Required: no restart and no extra reads; exactly one done per job.
- Reset mid-job:
  - Stimulus: rst=0 during PRESENT of pair 3.
  - Required: out_valid=0 and k=0 next cycle; no done pulse; a following start re-fetches from addr 0.
